// File: rtl/eprisc_iocontroller_pkg.sv
// Shared constants for the epRISC I/O controller.
// Holds the register map, STATUS bit positions, default ID and the UART FSM state types.
package eprisc_ioc_pkg;

  typedef logic [6:0] reg_addr_t;

  localparam reg_addr_t AddrId        = 7'h00;
  localparam reg_addr_t AddrStatus    = 7'h01;
  localparam reg_addr_t AddrData      = 7'h02;
  localparam reg_addr_t AddrGpioOutLo = 7'h03;
  localparam reg_addr_t AddrGpioOutHi = 7'h04;
  localparam reg_addr_t AddrGpioDirLo = 7'h05;
  localparam reg_addr_t AddrGpioDirHi = 7'h06;
  localparam reg_addr_t AddrGpioInLo  = 7'h07;
  localparam reg_addr_t AddrGpioInHi  = 7'h08;
  localparam reg_addr_t AddrIrqEn     = 7'h09;
  localparam reg_addr_t AddrDbgOut    = 7'h0A;
  localparam reg_addr_t AddrDbgDir    = 7'h0B;

  localparam int unsigned StatRxValid = 0;
  localparam int unsigned StatTxBusy  = 1;
  localparam int unsigned StatOverrun = 2;
  localparam int unsigned StatFraming = 3;
  localparam int unsigned StatRstPin  = 4;

  localparam logic [7:0] IdDefault = 8'h5A;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

endpackage

// File: rtl/eprisc_iocontroller_if.sv
// CPU parallel peripheral bus as seen between the CPU (master) and an I/O slave.
// Signal names keep the CPU-side view, so iBus* are driven by the slave.
interface eprisc_iocontroller_if;
  logic       oBusClock;
  logic [0:1] oBusSelect;
  logic [0:7] oBusMOSI;
  logic [0:7] iBusMISO;
  logic       iBusInterrupt;

  modport master (
    output oBusClock, oBusSelect, oBusMOSI,
    input  iBusMISO, iBusInterrupt
  );

  modport slave (
    input  oBusClock, oBusSelect, oBusMOSI,
    output iBusMISO, iBusInterrupt
  );
endinterface

// File: rtl/eprisc_ioc_uart.sv
// 8N1 UART transmitter and receiver, LSB first, one bit every CLKS_PER_BIT clocks.
// RX is synchronized here; bytes are reported with single-cycle done/error pulses.
module eprisc_ioc_uart
  import eprisc_ioc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 33
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_o,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       rx_err_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'((CLKS_PER_BIT - 1) / 2);

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_err_q, rx_err_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;

  logic tx_wrap, rx_wrap, rx_fall;

  assign tx_wrap = (tx_cnt_q == CntLast);
  assign rx_wrap = (rx_cnt_q == CntLast);
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_start_i) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_shift_d = tx_data_i;
        end
      end
      TxStart: begin
        if (tx_wrap) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxData: begin
        if (tx_wrap) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxStop: begin
        if (tx_wrap) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Line level follows the next state so the start bit appears on the same edge as TxStart.
    unique case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntMid) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (rx_wrap) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (rx_wrap) begin
          rx_state_d = RxIdle;
          rx_cnt_d   = '0;
          rx_done_d  = rx_s2_q;
          rx_err_d   = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  assign tx_busy_o = (tx_state_q != TxIdle);
  assign tx_o      = tx_q;
  assign rx_data_o = rx_shift_q;
  assign rx_done_o = rx_done_q;
  assign rx_err_o  = rx_err_q;

endmodule

// File: rtl/eprisc_iocontroller.sv
// epRISC I/O controller: bus slave register file over a TTL UART, 16 GPIOs and 6 debug pins.
// Define IOC_RS232_MIRROR_EN to mirror the UART onto the RS232 port.
module eprisc_iocontroller
  import eprisc_ioc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 33,
  parameter logic [7:0]  ID_VALUE     = IdDefault
) (
  input  logic       iBoardClock,
  input  logic       iBoardReset,
  eprisc_iocontroller_if.slave bus,
  inout  wire        bBoardDebug0, bBoardDebug1, bBoardDebug2,
  inout  wire        bBoardDebug3, bBoardDebug4, bBoardDebug5,
  output logic       oSerialDTR,
  output logic       oSerialRTS,
  output logic       oSerialTX,
  input  logic       iSerialRX,
  input  logic       iSerialCTS,
  input  logic       iSerialDCD,
  input  logic       iSerialDSR,
  output logic       oTTLSerialTX,
  input  logic       iTTLSerialRX,
  input  logic       iTTLSerialRST,
  inout  wire        bGPIO0, bGPIO1, bGPIO2, bGPIO3, bGPIO4, bGPIO5, bGPIO6, bGPIO7,
  inout  wire        bGPIO8, bGPIO9, bGPIO10, bGPIO11, bGPIO12, bGPIO13, bGPIO14, bGPIO15,
  output logic [3:0] oExtBusMOSI,
  output logic [1:0] oExtBusSS,
  output logic       oExtBusClock,
  input  logic [3:0] iExtBusMISO,
  input  logic       iExtBusInterrupt,
  output logic       oSPIMOSI,
  output logic       oSPISelect,
  output logic       oSPIClock,
  input  logic       iSPIMISO,
  input  logic       iSPIDetect0,
  input  logic       iSPIDetect1,
  input  logic       iSPIWrite0,
  input  logic       iSPIWrite1,
  output logic [7:0] oVGAColor,
  output logic       oVGAHorizontal,
  output logic       oVGAVertical,
  inout  wire        bPS2Data,
  inout  wire        bPS2Clock
);

  logic       bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic [1:0] bsel_s1_q, bsel_s2_q;
  logic [7:0] bmosi_s1_q, bmosi_s2_q;
  logic [15:0] gpio_s1_q, gpio_s2_q;
  logic       rstpin_s1_q, rstpin_s2_q;

  logic       cap_vld_q, cap_vld_d;
  logic [7:0] cap_byte_q, cap_byte_d;
  logic [1:0] cap_idx_q, cap_idx_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic       cmd_rd_q, cmd_rd_d;
  reg_addr_t  cmd_addr_q, cmd_addr_d;

  logic [15:0] gpio_out_q, gpio_out_d;
  logic [15:0] gpio_dir_q, gpio_dir_d;
  logic [3:0]  irq_en_q, irq_en_d;
  logic [5:0]  dbg_out_q, dbg_out_d;
  logic [5:0]  dbg_dir_q, dbg_dir_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        overrun_q, overrun_d;
  logic        framing_q, framing_d;
  logic [7:0]  miso_q, miso_d;
  logic        irq_q, irq_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        bus_sel, bus_rise, rd_stb, wr_stb, data_rd, stat_rd;
  reg_addr_t   rd_addr;
  logic [7:0]  rd_data, status;
  logic        tx_busy, uart_tx_busy, tx_line, rx_line, rx_done, rx_err;
  logic [7:0]  rx_byte;
  logic [15:0] gpio_pins;

  assign bus_sel  = (bsel_s2_q == 2'b01);
  assign bus_rise = bclk_s2_q & ~bclk_prev_q;
  // Captured bytes are acted on one cycle after capture.
  assign rd_stb   = cap_vld_q && (cap_idx_q == 2'd0) && cap_byte_q[7];
  assign rd_addr  = cap_byte_q[6:0];
  assign wr_stb   = cap_vld_q && (cap_idx_q == 2'd1) && !cmd_rd_q;
  assign data_rd  = rd_stb && (rd_addr == AddrData);
  assign stat_rd  = rd_stb && (rd_addr == AddrStatus);

  assign tx_busy = uart_tx_busy | tx_start_q;
  assign status  = {3'b000, rstpin_s2_q, framing_q, overrun_q, tx_busy, rx_valid_q};

  assign gpio_pins = {bGPIO15, bGPIO14, bGPIO13, bGPIO12, bGPIO11, bGPIO10, bGPIO9, bGPIO8,
                      bGPIO7, bGPIO6, bGPIO5, bGPIO4, bGPIO3, bGPIO2, bGPIO1, bGPIO0};

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      AddrId:        rd_data = ID_VALUE;
      AddrStatus:    rd_data = status;
      AddrData:      rd_data = rx_data_q;
      AddrGpioOutLo: rd_data = gpio_out_q[7:0];
      AddrGpioOutHi: rd_data = gpio_out_q[15:8];
      AddrGpioDirLo: rd_data = gpio_dir_q[7:0];
      AddrGpioDirHi: rd_data = gpio_dir_q[15:8];
      AddrGpioInLo:  rd_data = gpio_s2_q[7:0];
      AddrGpioInHi:  rd_data = gpio_s2_q[15:8];
      AddrIrqEn:     rd_data = {4'h0, irq_en_q};
      AddrDbgOut:    rd_data = {2'b00, dbg_out_q};
      AddrDbgDir:    rd_data = {2'b00, dbg_dir_q};
      default:       rd_data = 8'h00;
    endcase
  end

  always_comb begin
    cap_vld_d  = bus_sel & bus_rise;
    cap_byte_d = cap_byte_q;
    cap_idx_d  = cap_idx_q;
    byte_cnt_d = byte_cnt_q;
    if (!bus_sel) begin
      byte_cnt_d = 2'd0;
    end else if (bus_rise) begin
      cap_byte_d = bmosi_s2_q;
      cap_idx_d  = byte_cnt_q;
      if (byte_cnt_q != 2'd2) byte_cnt_d = byte_cnt_q + 2'd1;
    end

    cmd_rd_d   = cmd_rd_q;
    cmd_addr_d = cmd_addr_q;
    if (cap_vld_q && (cap_idx_q == 2'd0)) begin
      cmd_rd_d   = cap_byte_q[7];
      cmd_addr_d = cap_byte_q[6:0];
    end

    miso_d = miso_q;
    if (!bus_sel)       miso_d = 8'h00;
    else if (rd_stb)    miso_d = rd_data;
    else if (cap_vld_q) miso_d = 8'h00;

    gpio_out_d = gpio_out_q;
    gpio_dir_d = gpio_dir_q;
    irq_en_d   = irq_en_q;
    dbg_out_d  = dbg_out_q;
    dbg_dir_d  = dbg_dir_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (wr_stb) begin
      case (cmd_addr_q)
        AddrData: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = cap_byte_q;
          end
        end
        AddrGpioOutLo: gpio_out_d[7:0]  = cap_byte_q;
        AddrGpioOutHi: gpio_out_d[15:8] = cap_byte_q;
        AddrGpioDirLo: gpio_dir_d[7:0]  = cap_byte_q;
        AddrGpioDirHi: gpio_dir_d[15:8] = cap_byte_q;
        AddrIrqEn:     irq_en_d         = cap_byte_q[3:0];
        AddrDbgOut:    dbg_out_d        = cap_byte_q[5:0];
        AddrDbgDir:    dbg_dir_d        = cap_byte_q[5:0];
        default:       ;
      endcase
    end

    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overrun_d  = overrun_q;
    framing_d  = framing_q;
    if (stat_rd) begin
      overrun_d = 1'b0;
      framing_d = 1'b0;
    end
    // A byte landing on the same cycle as a DATA read replaces it without an overrun.
    if (rx_done) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !data_rd) overrun_d = 1'b1;
    end else if (data_rd) begin
      rx_valid_d = 1'b0;
    end
    if (rx_err) framing_d = 1'b1;

    irq_d = |(status[3:0] & irq_en_q);
  end

  always_ff @(posedge iBoardClock) begin
    if (iBoardReset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      bsel_s1_q   <= 2'b00;
      bsel_s2_q   <= 2'b00;
      bmosi_s1_q  <= 8'h00;
      bmosi_s2_q  <= 8'h00;
      gpio_s1_q   <= 16'h0000;
      gpio_s2_q   <= 16'h0000;
      rstpin_s1_q <= 1'b0;
      rstpin_s2_q <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_byte_q  <= 8'h00;
      cap_idx_q   <= 2'd0;
      byte_cnt_q  <= 2'd0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= '0;
      gpio_out_q  <= 16'h0000;
      gpio_dir_q  <= 16'h0000;
      irq_en_q    <= 4'h0;
      dbg_out_q   <= 6'h00;
      dbg_dir_q   <= 6'h00;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
      framing_q   <= 1'b0;
      miso_q      <= 8'h00;
      irq_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      bclk_s1_q   <= bus.oBusClock;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      bsel_s1_q   <= bus.oBusSelect;
      bsel_s2_q   <= bsel_s1_q;
      bmosi_s1_q  <= bus.oBusMOSI;
      bmosi_s2_q  <= bmosi_s1_q;
      gpio_s1_q   <= gpio_pins;
      gpio_s2_q   <= gpio_s1_q;
      rstpin_s1_q <= iTTLSerialRST;
      rstpin_s2_q <= rstpin_s1_q;
      cap_vld_q   <= cap_vld_d;
      cap_byte_q  <= cap_byte_d;
      cap_idx_q   <= cap_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_addr_q  <= cmd_addr_d;
      gpio_out_q  <= gpio_out_d;
      gpio_dir_q  <= gpio_dir_d;
      irq_en_q    <= irq_en_d;
      dbg_out_q   <= dbg_out_d;
      dbg_dir_q   <= dbg_dir_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      framing_q   <= framing_d;
      miso_q      <= miso_d;
      irq_q       <= irq_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  eprisc_ioc_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i     (iBoardClock),
    .rst_i     (iBoardReset),
    .tx_start_i(tx_start_q),
    .tx_data_i (tx_data_q),
    .tx_busy_o (uart_tx_busy),
    .tx_o      (tx_line),
    .rx_i      (rx_line),
    .rx_data_o (rx_byte),
    .rx_done_o (rx_done),
    .rx_err_o  (rx_err)
  );

  assign bus.iBusMISO      = miso_q;
  assign bus.iBusInterrupt = irq_q;
  assign oTTLSerialTX      = tx_line;
  assign oSerialDTR        = 1'b1;

  logic unused_inputs;
`ifdef IOC_RS232_MIRROR_EN
  assign rx_line    = iTTLSerialRX & iSerialRX;
  assign oSerialTX  = tx_line;
  assign oSerialRTS = rx_valid_q;
  assign unused_inputs = ^{iSerialCTS, iSerialDCD, iSerialDSR, iExtBusMISO, iExtBusInterrupt,
                           iSPIMISO, iSPIDetect0, iSPIDetect1, iSPIWrite0, iSPIWrite1};
`else
  assign rx_line    = iTTLSerialRX;
  assign oSerialTX  = 1'b1;
  assign oSerialRTS = 1'b1;
  assign unused_inputs = ^{iSerialRX, iSerialCTS, iSerialDCD, iSerialDSR, iExtBusMISO,
                           iExtBusInterrupt, iSPIMISO, iSPIDetect0, iSPIDetect1, iSPIWrite0,
                           iSPIWrite1};
`endif

  assign oExtBusMOSI    = 4'h0;
  assign oExtBusSS      = 2'b11;
  assign oExtBusClock   = 1'b0;
  assign oSPIMOSI       = 1'b1;
  assign oSPISelect     = 1'b1;
  assign oSPIClock      = 1'b0;
  assign oVGAColor      = 8'h00;
  assign oVGAHorizontal = 1'b1;
  assign oVGAVertical   = 1'b1;
  assign bPS2Data       = 1'bz;
  assign bPS2Clock      = 1'bz;

  assign bGPIO0  = gpio_dir_q[0]  ? gpio_out_q[0]  : 1'bz;
  assign bGPIO1  = gpio_dir_q[1]  ? gpio_out_q[1]  : 1'bz;
  assign bGPIO2  = gpio_dir_q[2]  ? gpio_out_q[2]  : 1'bz;
  assign bGPIO3  = gpio_dir_q[3]  ? gpio_out_q[3]  : 1'bz;
  assign bGPIO4  = gpio_dir_q[4]  ? gpio_out_q[4]  : 1'bz;
  assign bGPIO5  = gpio_dir_q[5]  ? gpio_out_q[5]  : 1'bz;
  assign bGPIO6  = gpio_dir_q[6]  ? gpio_out_q[6]  : 1'bz;
  assign bGPIO7  = gpio_dir_q[7]  ? gpio_out_q[7]  : 1'bz;
  assign bGPIO8  = gpio_dir_q[8]  ? gpio_out_q[8]  : 1'bz;
  assign bGPIO9  = gpio_dir_q[9]  ? gpio_out_q[9]  : 1'bz;
  assign bGPIO10 = gpio_dir_q[10] ? gpio_out_q[10] : 1'bz;
  assign bGPIO11 = gpio_dir_q[11] ? gpio_out_q[11] : 1'bz;
  assign bGPIO12 = gpio_dir_q[12] ? gpio_out_q[12] : 1'bz;
  assign bGPIO13 = gpio_dir_q[13] ? gpio_out_q[13] : 1'bz;
  assign bGPIO14 = gpio_dir_q[14] ? gpio_out_q[14] : 1'bz;
  assign bGPIO15 = gpio_dir_q[15] ? gpio_out_q[15] : 1'bz;

  assign bBoardDebug0 = dbg_dir_q[0] ? dbg_out_q[0] : 1'bz;
  assign bBoardDebug1 = dbg_dir_q[1] ? dbg_out_q[1] : 1'bz;
  assign bBoardDebug2 = dbg_dir_q[2] ? dbg_out_q[2] : 1'bz;
  assign bBoardDebug3 = dbg_dir_q[3] ? dbg_out_q[3] : 1'bz;
  assign bBoardDebug4 = dbg_dir_q[4] ? dbg_out_q[4] : 1'bz;
  assign bBoardDebug5 = dbg_dir_q[5] ? dbg_out_q[5] : 1'bz;

endmodule

// File: tb/tb_eprisc_iocontroller.sv
// Directed bench for eprisc_iocontroller: bus register access, GPIO, debug pins, UART TX/RX and IRQ.
`timescale 1ns/1ps
module tb_eprisc_iocontroller;

  logic clk = 1'b0;
  logic rst;
  logic ttl_rx, ttl_rst_pin, ser_rx;
  logic ser_dtr, ser_rts, ser_tx, ttl_tx;
  logic [3:0] ext_mosi;
  logic [1:0] ext_ss;
  logic ext_clk, spi_mosi, spi_sel, spi_clk, vga_h, vga_v;
  logic [7:0] vga_color;
  wire [15:0] gpio;
  wire [5:0]  dbg;
  wire ps2_d, ps2_c;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd;
  logic [9:0] frame;

  eprisc_iocontroller_if bus ();

  eprisc_iocontroller #(
    .CLKS_PER_BIT(33),
    .ID_VALUE    (8'h5A)
  ) dut (
    .iBoardClock     (clk),
    .iBoardReset     (rst),
    .bus             (bus),
    .bBoardDebug0    (dbg[0]),
    .bBoardDebug1    (dbg[1]),
    .bBoardDebug2    (dbg[2]),
    .bBoardDebug3    (dbg[3]),
    .bBoardDebug4    (dbg[4]),
    .bBoardDebug5    (dbg[5]),
    .oSerialDTR      (ser_dtr),
    .oSerialRTS      (ser_rts),
    .oSerialTX       (ser_tx),
    .iSerialRX       (ser_rx),
    .iSerialCTS      (1'b0),
    .iSerialDCD      (1'b0),
    .iSerialDSR      (1'b0),
    .oTTLSerialTX    (ttl_tx),
    .iTTLSerialRX    (ttl_rx),
    .iTTLSerialRST   (ttl_rst_pin),
    .bGPIO0          (gpio[0]),
    .bGPIO1          (gpio[1]),
    .bGPIO2          (gpio[2]),
    .bGPIO3          (gpio[3]),
    .bGPIO4          (gpio[4]),
    .bGPIO5          (gpio[5]),
    .bGPIO6          (gpio[6]),
    .bGPIO7          (gpio[7]),
    .bGPIO8          (gpio[8]),
    .bGPIO9          (gpio[9]),
    .bGPIO10         (gpio[10]),
    .bGPIO11         (gpio[11]),
    .bGPIO12         (gpio[12]),
    .bGPIO13         (gpio[13]),
    .bGPIO14         (gpio[14]),
    .bGPIO15         (gpio[15]),
    .oExtBusMOSI     (ext_mosi),
    .oExtBusSS       (ext_ss),
    .oExtBusClock    (ext_clk),
    .iExtBusMISO     (4'h0),
    .iExtBusInterrupt(1'b0),
    .oSPIMOSI        (spi_mosi),
    .oSPISelect      (spi_sel),
    .oSPIClock       (spi_clk),
    .iSPIMISO        (1'b0),
    .iSPIDetect0     (1'b0),
    .iSPIDetect1     (1'b0),
    .iSPIWrite0      (1'b0),
    .iSPIWrite1      (1'b0),
    .oVGAColor       (vga_color),
    .oVGAHorizontal  (vga_h),
    .oVGAVertical    (vga_v),
    .bPS2Data        (ps2_d),
    .bPS2Clock       (ps2_c)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_byte(input logic [7:0] b);
    bus.oBusMOSI = b;
    cyc(4);
    bus.oBusClock = 1'b1;
    cyc(5);
    bus.oBusClock = 1'b0;
    cyc(4);
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
    bus.oBusSelect = 2'b01;
    cyc(4);
    bus_byte({1'b1, a});
    d = bus.iBusMISO;
    bus.oBusSelect = 2'b00;
    cyc(5);
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    bus.oBusSelect = 2'b01;
    cyc(4);
    bus_byte({1'b0, a});
    bus_byte(d);
    bus.oBusSelect = 2'b00;
    cyc(5);
  endtask

  task automatic uart_send(input logic [7:0] b);
    ttl_rx = 1'b0;
    cyc(33);
    for (int i = 0; i < 8; i++) begin
      ttl_rx = b[i];
      cyc(33);
    end
    ttl_rx = 1'b1;
    cyc(33);
  endtask

  initial begin
    rst = 1'b1;
    ttl_rx = 1'b1;
    ser_rx = 1'b1;
    ttl_rst_pin = 1'b0;
    bus.oBusClock = 1'b0;
    bus.oBusSelect = 2'b00;
    bus.oBusMOSI = 8'h00;
    cyc(5);

    check("rst_miso", bus.iBusMISO, 16'h0000);
    check("rst_irq", bus.iBusInterrupt, 16'h0000);
    check("rst_ttl_tx", ttl_tx, 16'h0001);
    check("rst_ser_tx", ser_tx, 16'h0001);
    check("rst_ser_dtr", ser_dtr, 16'h0001);
    check("rst_ser_rts", ser_rts, 16'h0001);
    check("idle_ext_ss", ext_ss, 16'h0003);
    check("idle_spi_sel", spi_sel, 16'h0001);
    check("idle_vga_h", vga_h, 16'h0001);
    rst = 1'b0;
    cyc(2);

    bus_read(7'h05, rd); check("gpio_dir_lo_rst", rd, 16'h0000);
    bus_read(7'h06, rd); check("gpio_dir_hi_rst", rd, 16'h0000);

    bus_read(7'h00, rd); check("id_read", rd, 16'h005A);
    check("miso_after_deselect", bus.iBusMISO, 16'h0000);
    bus_read(7'h7F, rd); check("unmapped_read", rd, 16'h0000);

    bus_write(7'h05, 8'hFF);
    bus_write(7'h03, 8'hA5);
    check("gpio_pins_lo", {8'h00, gpio[7:0]}, 16'h00A5);
    bus_read(7'h07, rd); check("gpio_in_lo", rd, 16'h00A5);
    bus_read(7'h03, rd); check("gpio_out_lo", rd, 16'h00A5);

    bus_write(7'h0A, 8'h15);
    bus_write(7'h0B, 8'h3F);
    check("debug_pins", {10'h000, dbg}, 16'h0015);

    // TX: start bit is expected on the 5th clock after the data strobe rises.
    bus.oBusSelect = 2'b01;
    cyc(4);
    bus_byte({1'b0, 7'h02});
    bus.oBusMOSI = 8'h41;
    cyc(4);
    bus.oBusClock = 1'b1;
    cyc(4);
    check("tx_before_start", ttl_tx, 16'h0001);
    cyc(1);
    check("tx_start_edge", ttl_tx, 16'h0000);
    bus.oBusClock = 1'b0;
    bus.oBusSelect = 2'b00;
    frame = {1'b1, 8'h41, 1'b0};
    cyc(16);
    check("tx_bit0", ttl_tx, {15'h0000, frame[0]});
    for (int i = 1; i < 10; i++) begin
      cyc(33);
      check($sformatf("tx_bit%0d", i), ttl_tx, {15'h0000, frame[i]});
    end
    bus_read(7'h01, rd); check("tx_busy_end_of_frame", rd, 16'h0002);
    cyc(20);
    bus_read(7'h01, rd); check("tx_busy_cleared", rd, 16'h0000);

    ttl_rst_pin = 1'b1;
    cyc(4);
    bus_read(7'h01, rd); check("status_rst_pin", rd, 16'h0010);
    ttl_rst_pin = 1'b0;
    cyc(4);

    // 305 cycles low: start plus eight zero bits, then a good stop bit.
    ttl_rx = 1'b0;
    cyc(305);
    ttl_rx = 1'b1;
    cyc(40);
    bus_read(7'h01, rd); check("rx_status_valid", rd, 16'h0001);
    bus_read(7'h02, rd); check("rx_data_zero", rd, 16'h0000);
    bus_read(7'h01, rd); check("rx_valid_cleared", rd, 16'h0000);

    ttl_rx = 1'b0;
    cyc(400);
    ttl_rx = 1'b1;
    cyc(20);
    bus_read(7'h01, rd); check("rx_framing_err", rd, 16'h0008);
    bus_read(7'h01, rd); check("framing_cleared_by_read", rd, 16'h0000);

    bus_write(7'h09, 8'h01);
    bus_read(7'h09, rd); check("irq_en_readback", rd, 16'h0001);
    check("irq_idle", bus.iBusInterrupt, 16'h0000);
    uart_send(8'h3C);
    check("irq_after_byte1", bus.iBusInterrupt, 16'h0001);
    uart_send(8'hC3);
    cyc(5);
    bus_read(7'h01, rd); check("status_overrun", rd, 16'h0005);
    check("irq_after_status_read", bus.iBusInterrupt, 16'h0001);
    bus_read(7'h02, rd); check("rx_data_overwritten", rd, 16'h00C3);
    check("irq_cleared", bus.iBusInterrupt, 16'h0000);
    bus_read(7'h01, rd); check("status_final", rd, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
